// File: rtl/jelly2_img_sobel_calc.sv
// jelly2_img_sobel_calc: 3-stage pipelined 3x3 Sobel (gx, gy, saturated |gx|+|gy|, centre pixel) with side-band realigned to data
module jelly2_img_sobel_calc #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 0,
  parameter int MAG_SHIFT = 0,
  localparam int USER_BITS = USER_WIDTH > 0 ? USER_WIDTH : 1,
  localparam int GRAD_WIDTH = DATA_WIDTH + 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cke,
  input  logic                                 s_img_row_first,
  input  logic                                 s_img_row_last,
  input  logic                                 s_img_col_first,
  input  logic                                 s_img_col_last,
  input  logic                                 s_img_de,
  input  logic [USER_BITS-1:0]                 s_img_user,
  input  logic [2:0][2:0][DATA_WIDTH-1:0]      s_img_data,
  input  logic                                 s_img_valid,
  output logic                                 m_img_row_first,
  output logic                                 m_img_row_last,
  output logic                                 m_img_col_first,
  output logic                                 m_img_col_last,
  output logic                                 m_img_de,
  output logic [USER_BITS-1:0]                 m_img_user,
  output logic [DATA_WIDTH-1:0]                m_img_data,
  output logic signed [GRAD_WIDTH-1:0]         m_img_gx,
  output logic signed [GRAD_WIDTH-1:0]         m_img_gy,
  output logic [DATA_WIDTH-1:0]                m_img_mag,
  output logic                                 m_img_valid
);
  localparam int SW = DATA_WIDTH + 2;
  localparam int SBW = USER_BITS + 6;
  localparam logic [DATA_WIDTH-1:0] DMAX = '1;
  function automatic logic [SW-1:0] wsum(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b, input logic [DATA_WIDTH-1:0] c);
    return SW'(a) + SW'({b, 1'b0}) + SW'(c);
  endfunction
  logic [SW-1:0] s1_xp, s1_xn, s1_yp, s1_yn;
  logic [DATA_WIDTH-1:0] s1_d, s2_d;
  logic signed [GRAD_WIDTH-1:0] s2_gx, s2_gy;
  logic [2:0][SBW-1:0] sb;
  logic [GRAD_WIDTH-1:0] ax, ay, sum, shf;
  logic [DATA_WIDTH-1:0] mag;
  logic mask;
  always_comb begin
    ax = s2_gx[GRAD_WIDTH-1] ? $unsigned(-s2_gx) : $unsigned(s2_gx);
    ay = s2_gy[GRAD_WIDTH-1] ? $unsigned(-s2_gy) : $unsigned(s2_gy);
    sum = ax + ay;
    shf = sum >> MAG_SHIFT;
    mag = (shf > GRAD_WIDTH'(DMAX)) ? DMAX : shf[DATA_WIDTH-1:0];
    mask = sb[1][0] & sb[1][USER_BITS+1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_xp <= '0;
      s1_xn <= '0;
      s1_yp <= '0;
      s1_yn <= '0;
      s1_d <= '0;
      s2_d <= '0;
      s2_gx <= '0;
      s2_gy <= '0;
      sb <= '0;
      m_img_data <= '0;
      m_img_gx <= '0;
      m_img_gy <= '0;
      m_img_mag <= '0;
    end else if (cke) begin
      s1_xp <= wsum(s_img_data[0][2], s_img_data[1][2], s_img_data[2][2]);
      s1_xn <= wsum(s_img_data[0][0], s_img_data[1][0], s_img_data[2][0]);
      s1_yp <= wsum(s_img_data[2][0], s_img_data[2][1], s_img_data[2][2]);
      s1_yn <= wsum(s_img_data[0][0], s_img_data[0][1], s_img_data[0][2]);
      s1_d <= s_img_data[1][1];
      s2_gx <= $signed({1'b0, s1_xp}) - $signed({1'b0, s1_xn});
      s2_gy <= $signed({1'b0, s1_yp}) - $signed({1'b0, s1_yn});
      s2_d <= s1_d;
      sb <= {sb[1:0], {s_img_row_first, s_img_row_last, s_img_col_first, s_img_col_last, s_img_de, s_img_user, s_img_valid}};
      m_img_data <= s2_d;
      m_img_gx <= mask ? s2_gx : '0;
      m_img_gy <= mask ? s2_gy : '0;
      m_img_mag <= mask ? mag : '0;
    end
  end
  assign {m_img_row_first, m_img_row_last, m_img_col_first, m_img_col_last, m_img_de, m_img_user, m_img_valid} = sb[2];
endmodule

// File: tb/tb_jelly2_img_sobel_calc.sv
// tb_jelly2_img_sobel_calc: directed self-checking bench for the Sobel stage at MAG_SHIFT 0 and 2
`timescale 1ns/1ps
module tb_jelly2_img_sobel_calc;
  localparam int DW = 8;
  localparam int UW = 2;
  localparam int GW = DW + 3;
  typedef logic [2:0][2:0][DW-1:0] win_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cke = 1'b0;
  logic rf = 1'b0, rl = 1'b0, cf = 1'b0, cl = 1'b0, de = 1'b0, valid = 1'b0;
  logic [UW-1:0] user = '0;
  win_t win = '0;
  logic [1:0] o_rf, o_rl, o_cf, o_cl, o_de, o_valid;
  logic [UW-1:0] o_user [2];
  logic [DW-1:0] o_data [2];
  logic [DW-1:0] o_mag [2];
  logic signed [GW-1:0] o_gx [2];
  logic signed [GW-1:0] o_gy [2];
  int total = 0;
  int bad = 0;
  win_t bw [64];
  logic [3:0] bf [64];
  logic bde [64];
  logic bv [64];
  logic [UW-1:0] bu [64];
  always #5 clk = ~clk;
  jelly2_img_sobel_calc #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .MAG_SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .cke(cke),
    .s_img_row_first(rf), .s_img_row_last(rl), .s_img_col_first(cf), .s_img_col_last(cl),
    .s_img_de(de), .s_img_user(user), .s_img_data(win), .s_img_valid(valid),
    .m_img_row_first(o_rf[0]), .m_img_row_last(o_rl[0]), .m_img_col_first(o_cf[0]), .m_img_col_last(o_cl[0]),
    .m_img_de(o_de[0]), .m_img_user(o_user[0]), .m_img_data(o_data[0]), .m_img_gx(o_gx[0]),
    .m_img_gy(o_gy[0]), .m_img_mag(o_mag[0]), .m_img_valid(o_valid[0])
  );
  jelly2_img_sobel_calc #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .MAG_SHIFT(2)) dut2 (
    .clk(clk), .reset(reset), .cke(cke),
    .s_img_row_first(rf), .s_img_row_last(rl), .s_img_col_first(cf), .s_img_col_last(cl),
    .s_img_de(de), .s_img_user(user), .s_img_data(win), .s_img_valid(valid),
    .m_img_row_first(o_rf[1]), .m_img_row_last(o_rl[1]), .m_img_col_first(o_cf[1]), .m_img_col_last(o_cl[1]),
    .m_img_de(o_de[1]), .m_img_user(o_user[1]), .m_img_data(o_data[1]), .m_img_gx(o_gx[1]),
    .m_img_gy(o_gy[1]), .m_img_mag(o_mag[1]), .m_img_valid(o_valid[1])
  );
  function automatic int f_gx(input win_t w);
    return (int'(w[0][2]) + 2 * int'(w[1][2]) + int'(w[2][2])) - (int'(w[0][0]) + 2 * int'(w[1][0]) + int'(w[2][0]));
  endfunction
  function automatic int f_gy(input win_t w);
    return (int'(w[2][0]) + 2 * int'(w[2][1]) + int'(w[2][2])) - (int'(w[0][0]) + 2 * int'(w[0][1]) + int'(w[0][2]));
  endfunction
  function automatic int f_mag(input int gx, input int gy, input int sh);
    int s;
    s = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    s = s >> sh;
    return (s > 255) ? 255 : s;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    cke = 1'b0;
    {rf, rl, cf, cl, de, valid} = '1;
    user = '1;
    win = '1;
    step();
    step();
    total++;
    if ({o_rf, o_rl, o_cf, o_cl, o_de, o_valid, o_user[0], o_user[1]} !== '0) begin
      bad++;
      $display("FAIL reset_sideband: got %h want 0", {o_rf, o_rl, o_cf, o_cl, o_de, o_valid, o_user[0], o_user[1]});
    end
    total++;
    if ({o_data[0], o_gx[0], o_gy[0], o_mag[0], o_mag[1]} !== '0) begin
      bad++;
      $display("FAIL reset_data: got %h want 0", {o_data[0], o_gx[0], o_gy[0], o_mag[0], o_mag[1]});
    end
    reset = 1'b0;
    cke = 1'b1;
  endtask
  task automatic test_uniform();
    for (int y = 0; y < 3; y++) for (int x = 0; x < 3; x++) win[y][x] = 8'd100;
    {rf, rl, cf, cl} = 4'b1111;
    de = 1'b1;
    valid = 1'b1;
    user = 2'b10;
    step();
    step();
    total++;
    if (o_valid[0] !== 1'b0) begin
      bad++;
      $display("FAIL uniform_early_valid: got %b want 0", o_valid[0]);
    end
    step();
    total++;
    if ({o_valid[0], o_de[0], o_rf[0], o_rl[0], o_cf[0], o_cl[0], o_user[0]} !== 8'b11111110) begin
      bad++;
      $display("FAIL uniform_sideband: got %b want 11111110", {o_valid[0], o_de[0], o_rf[0], o_rl[0], o_cf[0], o_cl[0], o_user[0]});
    end
    total++;
    if (o_data[0] !== 8'd100 || o_gx[0] !== 11'sd0 || o_gy[0] !== 11'sd0 || o_mag[0] !== 8'd0) begin
      bad++;
      $display("FAIL uniform_result: got data=%0d gx=%0d gy=%0d mag=%0d want 100 0 0 0", o_data[0], o_gx[0], o_gy[0], o_mag[0]);
    end
  endtask
  task automatic test_vertical_edge();
    for (int y = 0; y < 3; y++) begin
      win[y][0] = 8'd0;
      win[y][1] = 8'd128;
      win[y][2] = 8'd255;
    end
    {rf, rl, cf, cl} = 4'b0000;
    user = 2'b01;
    step();
    step();
    step();
    total++;
    if (int'(o_gx[0]) !== 1020 || int'(o_gy[0]) !== 0) begin
      bad++;
      $display("FAIL edge_grad: got gx=%0d gy=%0d want 1020 0", o_gx[0], o_gy[0]);
    end
    total++;
    if (o_mag[0] !== 8'd255 || o_mag[1] !== 8'd255) begin
      bad++;
      $display("FAIL edge_mag: got m0=%0d m2=%0d want 255 255", o_mag[0], o_mag[1]);
    end
  endtask
  task automatic test_corner();
    win = '0;
    win[0][0] = 8'd255;
    step();
    step();
    step();
    total++;
    if (int'(o_gx[0]) !== -255 || int'(o_gy[0]) !== -255) begin
      bad++;
      $display("FAIL corner_grad: got gx=%0d gy=%0d want -255 -255", o_gx[0], o_gy[0]);
    end
    total++;
    if (o_mag[0] !== 8'd255 || o_mag[1] !== 8'd127) begin
      bad++;
      $display("FAIL corner_mag: got m0=%0d m2=%0d want 255 127", o_mag[0], o_mag[1]);
    end
  endtask
  task automatic test_mask();
    for (int y = 0; y < 3; y++) begin
      win[y][0] = 8'd0;
      win[y][1] = 8'd128;
      win[y][2] = 8'd255;
    end
    {rf, rl, cf, cl} = 4'b0101;
    user = 2'b11;
    de = 1'b0;
    valid = 1'b1;
    step();
    step();
    step();
    total++;
    if (o_gx[0] !== 11'sd0 || o_gy[0] !== 11'sd0 || o_mag[0] !== 8'd0 || o_mag[1] !== 8'd0) begin
      bad++;
      $display("FAIL mask_de_result: got gx=%0d gy=%0d m0=%0d m2=%0d want 0", o_gx[0], o_gy[0], o_mag[0], o_mag[1]);
    end
    total++;
    if ({o_data[0], o_rf[0], o_rl[0], o_cf[0], o_cl[0], o_de[0], o_valid[0], o_user[0]} !== {8'd128, 4'b0101, 2'b01, 2'b11}) begin
      bad++;
      $display("FAIL mask_de_pass: got %h want %h", {o_data[0], o_rf[0], o_rl[0], o_cf[0], o_cl[0], o_de[0], o_valid[0], o_user[0]}, {8'd128, 4'b0101, 2'b01, 2'b11});
    end
    de = 1'b1;
    valid = 1'b0;
    step();
    step();
    step();
    total++;
    if (o_gx[0] !== 11'sd0 || o_mag[0] !== 8'd0 || o_valid[0] !== 1'b0 || o_de[0] !== 1'b1) begin
      bad++;
      $display("FAIL mask_valid: got gx=%0d mag=%0d valid=%b de=%b want 0 0 0 1", o_gx[0], o_mag[0], o_valid[0], o_de[0]);
    end
  endtask
  task automatic test_stream(input int n, input int mode);
    int k;
    int cyc;
    int j;
    int eg;
    int ey;
    logic [4:0] pat;
    k = 0;
    cyc = 0;
    pat = 5'b10011;
    while (k < n + 2 && cyc < 1000) begin
      cke = (mode == 2) ? ((cyc < 5) ? pat[cyc] : 1'($urandom_range(0, 1))) : 1'b1;
      if (cke) begin
        for (int y = 0; y < 3; y++) for (int x = 0; x < 3; x++) bw[k][y][x] = 8'($urandom);
        bv[k] = (mode == 1 || mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        bde[k] = (mode == 2) ? 1'($urandom_range(0, 3) != 0) : 1'b1;
        bu[k] = UW'($urandom);
        bf[k] = (mode == 3) ? {((k % 32) < 8), ((k % 32) >= 24), ((k % 8) == 0), ((k % 8) == 7)} : 4'($urandom);
        win = bw[k];
        {rf, rl, cf, cl} = bf[k];
        de = bde[k];
        valid = bv[k];
        user = bu[k];
      end else begin
        win = win_t'({$urandom, $urandom, $urandom});
        {rf, rl, cf, cl, de, valid} = 6'($urandom);
        user = UW'($urandom);
      end
      step();
      cyc++;
      if (cke) k++;
      if (k >= 3) begin
        j = k - 3;
        eg = (bv[j] && bde[j]) ? f_gx(bw[j]) : 0;
        ey = (bv[j] && bde[j]) ? f_gy(bw[j]) : 0;
        total++;
        if ({o_rf[0], o_rl[0], o_cf[0], o_cl[0], o_de[0], o_valid[0], o_user[0]} !== {bf[j], bde[j], bv[j], bu[j]}) begin
          bad++;
          $display("FAIL stream%0d_sideband[%0d]: got %b want %b", mode, j, {o_rf[0], o_rl[0], o_cf[0], o_cl[0], o_de[0], o_valid[0], o_user[0]}, {bf[j], bde[j], bv[j], bu[j]});
        end
        total++;
        if (o_data[0] !== bw[j][1][1]) begin
          bad++;
          $display("FAIL stream%0d_data[%0d]: got %0d want %0d", mode, j, o_data[0], bw[j][1][1]);
        end
        total++;
        if (int'(o_gx[0]) !== eg || int'(o_gy[0]) !== ey) begin
          bad++;
          $display("FAIL stream%0d_grad[%0d]: got %0d,%0d want %0d,%0d", mode, j, o_gx[0], o_gy[0], eg, ey);
        end
        total++;
        if (int'(o_mag[0]) !== f_mag(eg, ey, 0) || int'(o_mag[1]) !== f_mag(eg, ey, 2)) begin
          bad++;
          $display("FAIL stream%0d_mag[%0d]: got %0d,%0d want %0d,%0d", mode, j, o_mag[0], o_mag[1], f_mag(eg, ey, 0), f_mag(eg, ey, 2));
        end
      end
    end
    total++;
    if (k < n + 2) begin
      bad++;
      $display("FAIL stream%0d_timeout: got %0d beats want %0d", mode, k, n + 2);
    end
    cke = 1'b1;
  endtask
  task automatic test_reset_midframe();
    test_stream(13, 3);
    reset = 1'b1;
    valid = 1'b1;
    de = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({o_rf, o_rl, o_cf, o_cl, o_de, o_valid, o_user[0], o_data[0], o_gx[0], o_gy[0], o_mag[0], o_mag[1]} !== '0) begin
      bad++;
      $display("FAIL midframe_reset: got %h want 0", {o_rf, o_rl, o_cf, o_cl, o_de, o_valid, o_user[0], o_data[0], o_gx[0], o_gy[0], o_mag[0], o_mag[1]});
    end
    win = '0;
    {rf, rl, cf, cl, de, valid} = '0;
    user = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if ({o_valid, o_de, o_rf, o_cf, o_data[0], o_gx[0]} !== '0) begin
        bad++;
        $display("FAIL midframe_stale[%0d]: got %h want 0", i, {o_valid, o_de, o_rf, o_cf, o_data[0], o_gx[0]});
      end
    end
    test_stream(32, 3);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_uniform();
    test_vertical_edge();
    test_corner();
    test_mask();
    test_stream(24, 0);
    test_stream(24, 1);
    test_stream(24, 2);
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
